switch_egress_port: RTL and testbench

//  Receive side of one switch_fabric_block output: captures every word the fabric

---
 rtl/switch_pkg.sv | 13 +
 rtl/egress_fifo_ram.sv | 24 ++
 rtl/switch_egress_port.sv | 129 ++++++++++++
 tb/tb_switch_egress_port.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared definitions for the switch fabric and its per-output egress ports.
package switch_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_PORTS  = 4;
  localparam int DEST_WIDTH = 2;

  typedef enum logic {
    EGR_EMPTY = 1'b0,
    EGR_HOLD  = 1'b1
  } egr_state_t;

endpackage

// File: rtl/egress_fifo_ram.sv
// Egress FIFO storage: synchronous write, asynchronous read.
module egress_fifo_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/switch_egress_port.sv
// Egress buffer for one fabric output: FIFO with registered output stage,
// drop-on-full accounting and a sticky overflow flag.
//
//   state     | meaning
//   EGR_EMPTY | no word in the output register, level = 0
//   EGR_HOLD  | output register holds the oldest buffered word
module switch_egress_port #(
  parameter int DATA_WIDTH = switch_pkg::DATA_WIDTH,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [CNT_WIDTH-1:0]         drop_count,
  output logic                         overflow,
  input  logic                         clear_stats
);
  import switch_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  egr_state_t             state, state_next;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0]  ram_rd_data;
  logic                   push, pop, drop;
  logic                   load_ram, load_bypass, load;

  // Every accepted word goes into the RAM; rd_ptr tracks the next word not yet
  // copied into the output register, so a full FIFO still has a free slot.
  egress_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  assign out_valid = (state == EGR_HOLD);
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & ((level < LVL_FULL) | pop);
  assign drop      = in_valid & ~push;
  assign load      = load_ram | load_bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EGR_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    load_ram    = 1'b0;
    load_bypass = 1'b0;
    case (state)
      EGR_EMPTY: begin
        if (push) begin
          load_bypass = 1'b1;
          state_next  = EGR_HOLD;
        end
      end
      EGR_HOLD: begin
        if (pop) begin
          if (level > LVL_ONE) begin
            load_ram = 1'b1;
          end else if (push) begin
            load_bypass = 1'b1;
          end else begin
            state_next = EGR_EMPTY;
          end
        end
      end
      default: state_next = EGR_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      out_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        out_data <= load_ram ? ram_rd_data : in_data;
      end
      if (push && !pop) begin
        level <= level + LVL_ONE;
      end else if (pop && !push) begin
        level <= level - LVL_ONE;
      end
    end
  end

  // Clear wins over a drop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clear_stats) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != {CNT_WIDTH{1'b1}}) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_switch_egress_port.sv
// Self-checking bench for switch_egress_port: directed tables, corner sequences
// and random traffic against a queue-based reference model.
module tb_switch_egress_port;

  localparam int DW      = 16;
  localparam int DEPTH   = 8;
  localparam int CW      = 2;
  localparam int CNT_MAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    level;
  logic [CW-1:0] drop_count;
  logic          overflow;
  logic          clear_stats;

  switch_egress_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .level       (level),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .clear_stats (clear_stats)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mq[$];
  int            m_cnt;
  bit            m_ovf;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          r;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    int            exp_lvl;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("level", 32'(level), 32'(mq.size()));
    chk("drop_count", 32'(drop_count), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
  endtask

  task automatic step(input logic iv, input logic [DW-1:0] d, input logic r, input logic c);
    bit mpop, mpush, mdrop;
    in_valid    = iv;
    in_data     = d;
    out_ready   = r;
    clear_stats = c;
    mpop  = (mq.size() > 0) && r;
    mpush = iv && ((mq.size() < DEPTH) || mpop);
    mdrop = iv && !mpush;
    @(posedge clk);
    #1;
    if (mpop) void'(mq.pop_front());
    if (mpush) mq.push_back(d);
    if (c) begin
      m_cnt = 0;
      m_ovf = 0;
    end else if (mdrop) begin
      m_ovf = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    check_model();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    clear_stats = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    m_cnt = 0;
    m_ovf = 0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_level", 32'(level), 0);
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] last, pd;
    logic          pv, r;
    int            dc;

    vt[0] = '{1'b1, 16'd7,  1'b1, 1'b1, 16'd7,  1};
    vt[1] = '{1'b1, 16'd8,  1'b1, 1'b1, 16'd8,  1};
    vt[2] = '{1'b1, 16'd9,  1'b1, 1'b1, 16'd9,  1};
    vt[3] = '{1'b1, 16'd10, 1'b1, 1'b1, 16'd10, 1};
    vt[4] = '{1'b0, 16'd0,  1'b1, 1'b0, 16'd0,  0};

    // 1: streaming with one-cycle latency
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(vt[i].iv, vt[i].d, vt[i].r, 1'b0);
      chk("t1_valid", 32'(out_valid), 32'(vt[i].exp_v));
      chk("t1_level", 32'(level), 32'(vt[i].exp_lvl));
      if (vt[i].exp_v) chk("t1_data", 32'(out_data), 32'(vt[i].exp_d));
    end

    // 2: fill past full, one drop, strict order on drain
    for (int i = 0; i < 9; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    chk("t2_level", 32'(level), 8);
    chk("t2_drop", 32'(drop_count), 1);
    chk("t2_ovf", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_order", 32'(out_data), 32'(i));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("t2_empty", 32'(out_valid), 0);

    // 3: push and pop together while full
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, DW'(100 + i), 1'b0, 1'b0);
    dc = int'(drop_count);
    step(1'b1, 16'd15, 1'b1, 1'b0);
    chk("t3_level", 32'(level), 8);
    chk("t3_nodrop", 32'(drop_count), 32'(dc));
    last = '0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) last = out_data;
      step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("t3_last", 32'(last), 15);

    // 4: ready toggling under continuous pushes
    for (int i = 0; i < 20; i++) begin
      r  = (i % 2 == 0);
      pv = out_valid;
      pd = out_data;
      step(1'b1, DW'(200 + i), r, 1'b0);
      if (pv && !r) chk("t4_hold", 32'(out_data), 32'(pd));
    end
    for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1, 1'b0);

    // 5: counter saturation, then clear beats a simultaneous drop
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, DW'(300 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'hdead, 1'b0, 1'b0);
    chk("t5_sat", 32'(drop_count), 3);
    chk("t5_ovf", 32'(overflow), 1);
    step(1'b1, 16'hbeef, 1'b0, 1'b1);
    chk("t5_clr_cnt", 32'(drop_count), 0);
    chk("t5_clr_ovf", 32'(overflow), 0);
    chk("t5_level", 32'(level), 8);

    // 6: asynchronous reset mid-burst
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DW'(50 + i), 1'b0, 1'b0);
    chk("t6_level5", 32'(level), 5);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 0);
    chk("t6_async_data", 32'(out_data), 0);
    chk("t6_async_level", 32'(level), 0);
    chk("t6_async_cnt", 32'(drop_count), 0);
    chk("t6_async_ovf", 32'(overflow), 0);
    #2 rst = 1'b0;
    mq.delete();
    m_cnt = 0;
    m_ovf = 0;
    step(1'b1, 16'd3, 1'b0, 1'b0);
    chk("t6_first", 32'(out_data), 3);
    chk("t6_level1", 32'(level), 1);

    // random traffic against the reference model
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 9) < 7), DW'($urandom),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
